// File: rtl/miner_pkg.sv
// Shared definitions for the miner CPU <-> host memory path.
package miner_pkg;

  // Words per host cache line (512-bit line / 32-bit word).
  localparam int WPL = 16;

  // CPU command encoding; 2'b11 is treated as a no-op.
  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10
  } op_t;

endpackage

// File: rtl/host_mem_ctrl_line_buffer.sv
// One cache line held as word slots: each slot is written either by a
// full-line load or by an indexed single-word write.
module line_buffer #(
  parameter int WORD_W = 32,
  parameter int LINE_W = 512,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_word,
  input  logic              load_en,
  input  logic [LINE_W-1:0] load_line,
  output logic [LINE_W-1:0] line
);

  localparam int WORDS = LINE_W / WORD_W;

  logic [WORD_W-1:0] words_reg [WORDS];

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      // Full-line load wins over a word write to the same slot.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          words_reg[gi] <= '0;
        end else if (load_en) begin
          words_reg[gi] <= load_line[gi*WORD_W +: WORD_W];
        end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
          words_reg[gi] <= wr_word;
        end
      end

      assign line[gi*WORD_W +: WORD_W] = words_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/host_mem_ctrl.sv
// Bridges 32-bit CPU word traffic to 512-bit host line DMA: one host line
// read streamed out as 16 words, or 16 collected words sent as one line write.
module host_mem_ctrl #(
  parameter int WORD_SIZE     = 32,
  parameter int CL_SIZE_WIDTH = 512,
  parameter int ADDR_BITCOUNT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     host_init,
  input  logic                     host_rd_ready,
  input  logic                     host_wr_ready,
  input  logic [1:0]               op,
  input  logic [ADDR_BITCOUNT-1:0] raw_address,
  input  logic [ADDR_BITCOUNT-1:0] address_offset,
  input  logic [WORD_SIZE-1:0]     common_data_bus_read_in,
  output logic [WORD_SIZE-1:0]     common_data_bus_write_out,
  input  logic [CL_SIZE_WIDTH-1:0] host_data_bus_read_in,
  output logic [CL_SIZE_WIDTH-1:0] host_data_bus_write_out,
  output logic [ADDR_BITCOUNT-1:0] corrected_address,
  output logic                     ready,
  output logic                     tx_done,
  output logic                     rd_valid,
  output logic                     host_re,
  output logic                     host_we,
  output logic                     host_rgo,
  output logic                     host_wgo
);
  import miner_pkg::*;

  localparam int WORDS    = CL_SIZE_WIDTH / WORD_SIZE;
  localparam int IDX_W    = $clog2(WORDS);
  localparam int LINE_BYTES = CL_SIZE_WIDTH / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [ADDR_BITCOUNT-1:0] LINE_MASK = ADDR_BITCOUNT'(LINE_BYTES - 1);

  typedef enum logic [2:0] {
    WAIT_INIT,
    IDLE,
    RD_REQ,
    RD_STREAM,
    WR_COLLECT,
    WR_REQ
  } state_t;

  state_t state_reg, state_next;
  logic                     first_reg;
  logic [IDX_W-1:0]         rd_idx_reg;
  logic [IDX_W-1:0]         wr_idx_reg;
  logic [ADDR_BITCOUNT-1:0] addr_reg;
  logic [CL_SIZE_WIDTH-1:0] rd_line;
  logic [ADDR_BITCOUNT-1:0] line_addr;
  logic                     accept;
  logic                     wr_word_en;
  logic                     rd_load;

  // Requests always target the start of the containing cache line.
  assign line_addr = raw_address & ~LINE_MASK;

  assign corrected_address         = addr_reg;
  assign common_data_bus_write_out = rd_line[rd_idx_reg*WORD_SIZE +: WORD_SIZE];

  // State register plus a flag marking the first cycle of a host request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= WAIT_INIT;
      first_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      first_reg <= (state_next != state_reg) &&
                   ((state_next == RD_REQ) || (state_next == WR_REQ));
    end
  end

  // Next-state and output decode; op is only looked at in IDLE.
  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    tx_done    = 1'b0;
    rd_valid   = 1'b0;
    host_re    = 1'b0;
    host_we    = 1'b0;
    host_rgo   = 1'b0;
    host_wgo   = 1'b0;
    accept     = 1'b0;
    wr_word_en = 1'b0;
    rd_load    = 1'b0;
    case (state_reg)
      WAIT_INIT: begin
        if (host_init) state_next = IDLE;
      end
      IDLE: begin
        ready = 1'b1;
        if (!host_init) begin
          state_next = WAIT_INIT;
        end else if (op == OP_READ) begin
          accept     = 1'b1;
          state_next = RD_REQ;
        end else if (op == OP_WRITE) begin
          accept     = 1'b1;
          wr_word_en = 1'b1;
          state_next = WR_COLLECT;
        end
      end
      RD_REQ: begin
        host_re  = 1'b1;
        host_rgo = first_reg;
        if (host_rd_ready) begin
          rd_load    = 1'b1;
          state_next = RD_STREAM;
        end
      end
      RD_STREAM: begin
        rd_valid = 1'b1;
        if (rd_idx_reg == LAST_IDX) begin
          tx_done    = 1'b1;
          state_next = IDLE;
        end
      end
      WR_COLLECT: begin
        wr_word_en = 1'b1;
        if (wr_idx_reg == LAST_IDX) state_next = WR_REQ;
      end
      WR_REQ: begin
        host_we  = 1'b1;
        host_wgo = first_reg;
        if (host_wr_ready) begin
          tx_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = WAIT_INIT;
    endcase
  end

  // Address capture and word indices. The write index wraps back to 0 after
  // the 16th word; the read index parks on the last word so the final word
  // stays visible on the CPU bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg   <= '0;
      rd_idx_reg <= '0;
      wr_idx_reg <= '0;
    end else begin
      if (accept) addr_reg <= address_offset + line_addr;
      if (wr_word_en) wr_idx_reg <= wr_idx_reg + IDX_W'(1);
      if (rd_load) begin
        rd_idx_reg <= '0;
      end else if ((state_reg == RD_STREAM) && (rd_idx_reg != LAST_IDX)) begin
        rd_idx_reg <= rd_idx_reg + IDX_W'(1);
      end
    end
  end

  // Separate read and write lines so a read never disturbs the last
  // assembled write line and vice versa.
  line_buffer #(
    .WORD_W (WORD_SIZE),
    .LINE_W (CL_SIZE_WIDTH),
    .IDX_W  (IDX_W)
  ) u_wr_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_word_en),
    .wr_idx    (wr_idx_reg),
    .wr_word   (common_data_bus_read_in),
    .load_en   (1'b0),
    .load_line ('0),
    .line      (host_data_bus_write_out)
  );

  line_buffer #(
    .WORD_W (WORD_SIZE),
    .LINE_W (CL_SIZE_WIDTH),
    .IDX_W  (IDX_W)
  ) u_rd_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_word   ('0),
    .load_en   (rd_load),
    .load_line (host_data_bus_read_in),
    .line      (rd_line)
  );

endmodule

// File: tb/tb_host_mem_ctrl.sv
// Self-checking bench for host_mem_ctrl: a table of line transactions with a
// queue scoreboard, plus hand-written init, host_init and reset sequences.
module tb_host_mem_ctrl;
  import miner_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         host_init;
  logic         host_rd_ready;
  logic         host_wr_ready;
  logic [1:0]   op;
  logic [63:0]  raw_address;
  logic [63:0]  address_offset;
  logic [31:0]  common_data_bus_read_in;
  logic [31:0]  common_data_bus_write_out;
  logic [511:0] host_data_bus_read_in;
  logic [511:0] host_data_bus_write_out;
  logic [63:0]  corrected_address;
  logic         ready;
  logic         tx_done;
  logic         rd_valid;
  logic         host_re;
  logic         host_we;
  logic         host_rgo;
  logic         host_wgo;

  host_mem_ctrl dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .host_init                 (host_init),
    .host_rd_ready             (host_rd_ready),
    .host_wr_ready             (host_wr_ready),
    .op                        (op),
    .raw_address               (raw_address),
    .address_offset            (address_offset),
    .common_data_bus_read_in   (common_data_bus_read_in),
    .common_data_bus_write_out (common_data_bus_write_out),
    .host_data_bus_read_in     (host_data_bus_read_in),
    .host_data_bus_write_out   (host_data_bus_write_out),
    .corrected_address         (corrected_address),
    .ready                     (ready),
    .tx_done                   (tx_done),
    .rd_valid                  (rd_valid),
    .host_re                   (host_re),
    .host_we                   (host_we),
    .host_rgo                  (host_rgo),
    .host_wgo                  (host_wgo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_write;
    logic [63:0] raw;
    logic [63:0] off;
    logic [63:0] exp_addr;
    logic [31:0] base;
    int          lat;
    bit          busy;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    bit          last;
  } rd_exp_t;

  typedef struct {
    logic [511:0] line;
    logic [63:0]  addr;
  } wr_exp_t;

  localparam int NV = 7;
  vec_t    vecs [NV];
  rd_exp_t rd_q [$];
  wr_exp_t wr_q [$];
  rd_exp_t mon_rd;
  wr_exp_t mon_wr;

  int checks   = 0;
  int errors   = 0;
  int tx_count = 0;
  int tx_snap  = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] build_line(input logic [31:0] base);
    logic [511:0] l;
    l = '0;
    for (int k = 0; k < WPL; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  // Scoreboard side: pop expected read words and write lines as the DUT
  // presents them.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_done === 1'b1) tx_count++;
      if (rd_valid === 1'b1) begin
        check("rd_q_nonempty", rd_q.size() != 0, 1'b1);
        if (rd_q.size() != 0) begin
          mon_rd = rd_q.pop_front();
          check("rd_word", common_data_bus_write_out, mon_rd.data);
          check("rd_tx_done", tx_done, mon_rd.last);
        end
      end
      if ((tx_done === 1'b1) && (host_we === 1'b1)) begin
        check("wr_q_nonempty", wr_q.size() != 0, 1'b1);
        if (wr_q.size() != 0) begin
          mon_wr = wr_q.pop_front();
          check("wr_line", host_data_bus_write_out, mon_wr.line);
          check("wr_addr", corrected_address, mon_wr.addr);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit reached");
  end

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, ready, 1'b1);
  endtask

  task automatic do_read(input vec_t v);
    logic [511:0] line;
    int n;
    line = build_line(v.base);
    wait_ready("rd_start_ready");
    op = OP_READ;
    raw_address = v.raw;
    address_offset = v.off;
    @(posedge clk); #1;
    op = OP_NOP;
    for (int c = 0; c <= v.lat; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (c == v.lat) begin
        host_rd_ready = 1'b1;
        host_data_bus_read_in = line;
        for (int k = 0; k < WPL; k++) rd_q.push_back('{v.base + 32'(k), k == WPL - 1});
      end
      @(negedge clk);
      check("rd_host_re", host_re, 1'b1);
      check("rd_host_rgo", host_rgo, c == 0);
      check("rd_addr", corrected_address, v.exp_addr);
      check("rd_req_ready", ready, 1'b0);
    end
    @(posedge clk); #1;
    host_rd_ready = 1'b0;
    host_data_bus_read_in = ~line;
    if (v.busy) begin
      op = OP_WRITE;
      raw_address = 64'hDEAD_0000;
    end
    @(negedge clk);
    check("rd_first_valid", rd_valid, 1'b1);
    check("rd_first_word", common_data_bus_write_out, v.base);
    if (v.busy) begin
      repeat (3) @(posedge clk);
      #1;
      op = OP_NOP;
    end
    n = 0;
    while (rd_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    check("rd_stream_done", rd_q.size(), 0);
    @(negedge clk);
    check("rd_end_ready", ready, 1'b1);
    check("rd_end_host_re", host_re, 1'b0);
    check("rd_end_valid", rd_valid, 1'b0);
  endtask

  task automatic do_write(input vec_t v);
    wait_ready("wr_start_ready");
    op = OP_WRITE;
    raw_address = v.raw;
    address_offset = v.off;
    common_data_bus_read_in = v.base;
    wr_q.push_back('{build_line(v.base), v.exp_addr});
    for (int k = 1; k < WPL; k++) begin
      @(posedge clk); #1;
      common_data_bus_read_in = v.base + 32'(k);
      op = OP_READ;
      @(negedge clk);
      check("wr_collect_ready", ready, 1'b0);
    end
    @(posedge clk); #1;
    op = OP_NOP;
    common_data_bus_read_in = 32'hDEAD_BEEF;
    for (int c = 0; c <= v.lat; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (c == v.lat) host_wr_ready = 1'b1;
      @(negedge clk);
      check("wr_host_we", host_we, 1'b1);
      check("wr_host_wgo", host_wgo, c == 0);
      check("wr_tx_done", tx_done, c == v.lat);
      check("wr_addr_stable", corrected_address, v.exp_addr);
      check("wr_word0", host_data_bus_write_out[31:0], v.base);
      check("wr_word15", host_data_bus_write_out[511:480], v.base + 32'd15);
    end
    @(posedge clk); #1;
    host_wr_ready = 1'b0;
    @(negedge clk);
    check("wr_end_ready", ready, 1'b1);
    check("wr_end_host_we", host_we, 1'b0);
    check("wr_end_tx_done", tx_done, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    host_init = 1'b0;
    host_rd_ready = 1'b0;
    host_wr_ready = 1'b0;
    op = OP_READ;
    raw_address = '0;
    address_offset = '0;
    common_data_bus_read_in = '0;
    host_data_bus_read_in = '0;

    vecs[0] = '{1'b0, 64'h1234, 64'h1000_0000, 64'h1000_1200, 32'hA000_0000, 3, 1'b0};
    vecs[1] = '{1'b1, 64'h40, 64'h0, 64'h40, 32'h0000_00B0, 2, 1'b0};
    vecs[2] = '{1'b0, 64'h5, 64'h0, 64'h0, 32'hC000_0000, 0, 1'b1};
    vecs[3] = '{1'b0, 64'h80, 64'hFFFF_FFFF_FFFF_FFC0, 64'h40, 32'hD000_0000, 1, 1'b1};
    vecs[4] = '{1'b1, 64'h7FF, 64'h100, 64'h8C0, 32'hE000_0000, 0, 1'b0};
    vecs[5] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h80, 64'h40, 32'hF000_0000, 1, 1'b0};
    vecs[6] = '{1'b0, 64'h0, 64'h0, 64'h0, 32'h1111_0000, 2, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_flags", {ready, tx_done, rd_valid, host_re, host_we, host_rgo, host_wgo}, 7'd0);
    check("reset_addr", corrected_address, 64'd0);
    check("reset_cpu_word", common_data_bus_write_out, 32'd0);
    check("reset_host_line", host_data_bus_write_out, 512'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_init_ready", ready, 1'b0);
      check("no_init_host_re", host_re, 1'b0);
    end
    host_init = 1'b1;
    op = OP_NOP;
    @(negedge clk);
    check("init_ready", ready, 1'b1);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_write) do_write(vecs[i]);
      else do_read(vecs[i]);
      $display("txn %0d %s raw=%h off=%h addr=%h", i,
               vecs[i].is_write ? "write" : "read",
               vecs[i].raw, vecs[i].off, vecs[i].exp_addr);
    end
    check("wr_q_drained", wr_q.size(), 0);
    check("wr_line_hold", host_data_bus_write_out, build_line(32'hF000_0000));
    check("rd_word_hold", common_data_bus_write_out, 32'h1111_000F);

    // host_init dropped in IDLE returns to WAIT_INIT; op is ignored there.
    @(posedge clk); #1;
    host_init = 1'b0;
    @(posedge clk); #1;
    check("init_drop_ready", ready, 1'b0);
    host_init = 1'b1;
    op = OP_READ;
    @(posedge clk); #1;
    check("init_back_ready", ready, 1'b1);
    op = OP_NOP;

    // Reset while word 7 of a read is on the CPU bus.
    wait_ready("rst_rd_start_ready");
    op = OP_READ;
    raw_address = 64'h200;
    address_offset = 64'h0;
    @(posedge clk); #1;
    op = OP_NOP;
    host_rd_ready = 1'b1;
    host_data_bus_read_in = build_line(32'h7700_0000);
    for (int k = 0; k < WPL; k++) rd_q.push_back('{32'h7700_0000 + 32'(k), k == WPL - 1});
    @(posedge clk); #1;
    host_rd_ready = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("pre_reset_word7", common_data_bus_write_out, 32'h7700_0007);
    check("pre_reset_valid", rd_valid, 1'b1);
    tx_snap = tx_count;
    rst_n = 1'b0;
    #1;
    check("mid_reset_flags", {ready, tx_done, rd_valid, host_re, host_we, host_rgo, host_wgo}, 7'd0);
    check("mid_reset_addr", corrected_address, 64'd0);
    check("mid_reset_cpu_word", common_data_bus_write_out, 32'd0);
    check("mid_reset_host_line", host_data_bus_write_out, 512'd0);
    rd_q.delete();
    host_init = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_wait_init", ready, 1'b0);
    check("post_reset_no_tx_done", tx_count, tx_snap);
    host_init = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/host_mem_ctrl.md
Name: host_mem_ctrl

Overview:
- Host memory controller between the miner CPU's 32-bit word interface and the host's 512-bit cache-line DMA interface.
- Converts a CPU read request into one host line read, then streams the line to the CPU as 16 words.
- Collects 16 CPU words into one line and issues one host line write.
- Applies the host address offset to every request.

Parameters:
- WORD_SIZE, 32, CPU-side word width in bits.
- CL_SIZE_WIDTH, 512, host cache-line width in bits; words per line WPL = CL_SIZE_WIDTH/WORD_SIZE = 16.
- ADDR_BITCOUNT, 64, address width in bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- host_init  in  1  host ready for traffic; level-sensitive enable.
- host_rd_ready  in  1  host line-read data valid on host_data_bus_read_in.
- host_wr_ready  in  1  host accepted the pending line write.
- op  in  2  CPU command: 00 NOP, 01 READ, 10 WRITE, 11 NOP.
- raw_address  in  ADDR_BITCOUNT  CPU byte address.
- address_offset  in  ADDR_BITCOUNT  host base address.
- common_data_bus_read_in  in  WORD_SIZE  CPU write-data word.
- common_data_bus_write_out  out  WORD_SIZE  read-data word to CPU.
- host_data_bus_read_in  in  CL_SIZE_WIDTH  line from host.
- host_data_bus_write_out  out  CL_SIZE_WIDTH  line to host.
- corrected_address  out  ADDR_BITCOUNT  host address of the current line.
- ready  out  1  idle and able to accept op.
- tx_done  out  1  one-cycle pulse when a transaction completes.
- rd_valid  out  1  common_data_bus_write_out holds a valid word.
- host_re, host_we  out  1  read/write request level to host.
- host_rgo, host_wgo  out  1  one-cycle start pulses for read/write.

Behaviour:
- Reset: all outputs are 0, state WAIT_INIT, line buffer and word counter cleared.
- Reset asserted mid-transaction aborts it immediately with no tx_done.
- State WAIT_INIT:
  - ready=0.
  - Moves to IDLE on the first clock with host_init=1.
  - If host_init drops while in IDLE, return to WAIT_INIT. Ongoing transactions complete regardless of host_init.
- State IDLE:
  - ready=1.
  - op is sampled only in IDLE and ignored in every other state.
  - On acceptance, corrected_address is registered as address_offset + {raw_address[63:6],6'b0}. Addition wraps modulo 2^64.
  - op=READ -> RD_REQ.
  - op=WRITE -> word0 = common_data_bus_read_in captured same edge, then WR_COLLECT.
- RD_REQ:
  - host_re=1 held. host_rgo=1 only on the first cycle in this state.
  - On host_rd_ready=1, latch host_data_bus_read_in and go to RD_STREAM. host_rd_ready may arrive on the first cycle.
- RD_STREAM:
  - 16 consecutive cycles with rd_valid=1.
  - Word k = line[32k+31:32k], k=0..15, lowest word first.
  - tx_done=1 on the cycle word 15 is presented; then IDLE.
  - Read latency: request accept -> first word = 1 cycle after host_rd_ready.
- WR_COLLECT:
  - Captures words 1..15 on the next 15 consecutive clocks; word k goes to line[32k+31:32k].
  - The CPU must present one word per cycle.
  - Then WR_REQ.
- WR_REQ:
  - host_we=1 held; host_wgo=1 on the first cycle only.
  - host_data_bus_write_out and corrected_address stable throughout.
  - On host_wr_ready=1: tx_done=1 that cycle, then IDLE.
- Output values:
  - ready=0 in every state except IDLE.
  - host_data_bus_write_out holds the last assembled line.
  - common_data_bus_write_out holds the last word output.
  - corrected_address holds the last request address.
- No simultaneous read and write: the single FSM serialises them.

Decomposition:
- Shared package miner_pkg: op encoding enum (OP_NOP, OP_READ, OP_WRITE) and the words-per-line constant.
- The state enum is local to the module.
- Optional sub-module line_buffer: 512-bit register with word-indexed write, word-indexed read and full-line load.

Test Plan:
- Reset, then host_init=0, op=READ -> ready=0 and no host_re.
- Set host_init=1 -> ready=1 next cycle.
- Read:
  - Stimulus: raw_address=0x1234, address_offset=0x1000_0000, op=READ. host_rd_ready asserted 3 cycles later with line word k = 0xA000_0000+k.
  - Required: corrected_address=0x1000_1200; host_rgo one pulse; host_re high until ready; 16 rd_valid cycles carrying 0xA0000000..0xA000000F in order; tx_done on the 0xA000000F cycle.
- Write:
  - Stimulus: op=WRITE, raw_address=0x40, offset=0, words 0xB0..0xBF over 16 cycles; host_wr_ready after 2 cycles.
  - Required: host_write_out[31:0]=0xB0, [511:480]=0xBF; corrected_address=0x40; host_wgo one pulse; tx_done one cycle; ready returns.
- Zero-latency host:
  - Stimulus: host_rd_ready=1 already on the first RD_REQ cycle.
  - Required: data latched; streaming starts the next cycle.
- Reset mid-stream:
  - Stimulus: rst_n low at word 7 of a read.
  - Required: all outputs 0 immediately; no tx_done; after release, state WAIT_INIT.
- Address wrap and busy command:
  - Stimulus: offset=0xFFFF_FFFF_FFFF_FFC0, raw=0x80.
  - Required: corrected_address=0x40.
  - Stimulus: op=WRITE issued during RD_STREAM.
  - Required: ignored.
